i2c_target_regbank: RTL and testbench
=====================================

// Module: i2c_target_regbank
// PURPOSE
//  I2C target (slave) that answers a host I2C master at standard-mode rates and exposes an 8-bit register bank.
//  It lets an off-board controller, or a loopback i2c_com master, write and read FPGA-side audio config/status registers.
//  Protocol is 7-bit device address, then 8-bit register pointer, then data bytes, with pointer auto-increment.
//  The block oversamples SCL/SDA on clk_12M; it does not stretch the clock.
// PARAMETERS
//  DEV_ADDR  7'h10  7-bit device address (write byte 0x20, read byte 0x21)
//  NUM_REGS  64     register count; pointer width AW = clog2(NUM_REGS)
//  FILT_LEN  3      consecutive identical samples needed to accept an SCL/SDA level change
// PORTS
//  clk_12M       in     1   system clock, 12 MHz
//  rstn          in     1   synchronous, active-low reset
//  i2c_sclk      in     1   I2C clock from master
//  i2c_sdat      inout  1   I2C data; open-drain: drives 0 or Z, never 1
//  busy          out    1   high from an address-matched START until STOP or an unmatched/NACK abort
//  wr_stb        out    1   one-cycle pulse per accepted write byte
//  wr_addr       out    AW  register written (valid with wr_stb)
//  wr_data       out    8   byte written (valid with wr_stb)
//  host_rd_addr  in     AW  local read port address
//  host_rd_data  out    8   regbank[host_rd_addr], combinational
// BEHAVIOUR
//  Reset:
//   - SDA released; busy=0, wr_stb=0, wr_addr=0, wr_data=0.
//   - All registers and the pointer clear to 0; FSM goes to IDLE.
//   - A reset mid-transfer releases SDA on the next clk.
//  Input conditioning:
//   - 2-FF synchronizer, then a FILT_LEN glitch filter.
//   - Internal edges lag the pins by 2+FILT_LEN clk.
//   - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  Timing: bits are sampled on filtered SCL rise; SDA changes 1 clk after filtered SCL fall.
//  START detected in any state (repeated start included): go to DEV_ADDR, bit counter=0.
//  STOP detected in any state: go to IDLE, busy=0, SDA released.
//  FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
//  DEV_ADDR:
//   - Shift 8 bits MSB first.
//   - If [7:1]==DEV_ADDR, drive ACK and set busy.
//   - If R/W=0, next state is REG_ADDR.
//   - If R/W=1, next state is RD_DATA.
//   - If the address does not match: no ACK, go to WAIT_STOP.
//  REG_ADDR:
//   - If byte < NUM_REGS: ACK, load pointer, go to WR_DATA.
//   - Otherwise: NACK, pointer unchanged, go to WAIT_STOP.
//  WR_DATA:
//   - After the 8th bit: on the SCL fall, drive ACK.
//   - In the same clk: write regbank[ptr], pulse wr_stb with wr_addr=ptr, then ptr = ptr+1 mod NUM_REGS.
//  ACK handling: SDA is held low from the SCL fall after bit 8 until the following SCL fall, then released.
//  RD_DATA:
//   - On the SCL fall that ends the ACK, load shifter=regbank[ptr] and drive bit7.
//   - Shift out on each following fall.
//   - After 8 bits, release SDA and sample the master's bit on the next SCL rise.
//   - Master ACK (0): ptr = ptr+1 mod NUM_REGS, stay in RD_DATA.
//   - Master NACK (1): go to WAIT_STOP.
//  Simultaneous events:
//   - A host read of the address being written returns the old value in that clk and the new value after.
//   - START/STOP take priority over bit processing in the same clk.
//  A write burst past NUM_REGS-1 wraps to 0. There is no clock stretching and no general-call support.
// TESTING
//  1. Write 0x20,0x05,0xA5,STOP -> 3 ACKs; one wr_stb (addr 5, data A5); host_rd_addr=5 gives A5.
//  2. Write 0x20,0x3F,0x11,0x22 -> wr_stb at 0x3F=11 then 0x00=22 (wrap); ptr=1.
//  3. Address byte 0x22 -> SDA never driven; busy=0; no wr_stb until the next START.
//  4. After test 1: 0x20,0x05, Sr, 0x21, read 2 bytes ACK/NACK -> A5, regbank[6]; ptr ends at 7.
//  5. Write 0x20,0x40 -> NACK on the reg byte; following data bytes ignored; no wr_stb.
//  6. Assert rstn mid read byte -> SDA released the next clk and regs=0; next write transaction succeeds.

Source files
------------

// File: rtl/i2c_target_regbank.sv
// I2C target with an 8-bit register bank and auto-incrementing pointer.
// SCL/SDA are oversampled on clk_12M; SDA is open-drain, never driven high.
module i2c_target_regbank #(
    parameter logic [6:0] DEV_ADDR = 7'h10,
    parameter int         NUM_REGS = 64,
    parameter int         FILT_LEN = 3,
    localparam int        AW       = $clog2(NUM_REGS)
) (
    input  logic          clk_12M,
    input  logic          rstn,
    input  logic          i2c_sclk,
    inout  wire           i2c_sdat,
    output logic          busy,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] host_rd_addr,
    output logic [7:0]    host_rd_data
);

    localparam int FW = $clog2(FILT_LEN + 1);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] DEV_ADR   = 4'd1;
    localparam logic [3:0] DEV_ACK   = 4'd2;
    localparam logic [3:0] REG_ADDR  = 4'd3;
    localparam logic [3:0] REG_ACK   = 4'd4;
    localparam logic [3:0] WR_DATA   = 4'd5;
    localparam logic [3:0] WR_ACK    = 4'd6;
    localparam logic [3:0] RD_DATA   = 4'd7;
    localparam logic [3:0] RD_ACK    = 4'd8;
    localparam logic [3:0] WAIT_STOP = 4'd9;

    logic          scl_s1, scl_s2, sda_s1, sda_s2;
    logic          scl_f, sda_f, scl_fq, sda_fq;
    logic [FW-1:0] scl_cnt, sda_cnt;
    logic          scl_rise, scl_fall, sda_rise, sda_fall;
    logic          start_det, stop_det;

    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          rw;
    logic          sda_oe;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_inc;
    logic          reg_ok;
    logic [7:0]    regbank [NUM_REGS];

    assign i2c_sdat     = sda_oe ? 1'b0 : 1'bz;
    assign host_rd_data = regbank[host_rd_addr];

    assign scl_rise  = scl_f & ~scl_fq;
    assign scl_fall  = ~scl_f & scl_fq;
    assign sda_rise  = sda_f & ~sda_fq;
    assign sda_fall  = ~sda_f & sda_fq;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    assign ptr_inc = (ptr == AW'(NUM_REGS - 1)) ? '0 : ptr + AW'(1);
    assign reg_ok  = ({24'd0, shreg} < 32'(NUM_REGS));

    // Two-flop synchronizers; idle bus level is high
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= i2c_sclk;
            scl_s2 <= scl_s1;
            sda_s1 <= i2c_sdat;
            sda_s2 <= sda_s1;
        end
    end

    // Accept a level change only after FILT_LEN identical samples
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_fq  <= 1'b1;
            sda_fq  <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_fq <= scl_f;
            sda_fq <= sda_f;
            if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FW'(FILT_LEN - 1)) begin
                scl_f   <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + FW'(1);
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FW'(FILT_LEN - 1)) begin
                sda_f   <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + FW'(1);
            end
        end
    end

    // Protocol FSM, register bank and write strobe
    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            ptr     <= '0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regbank[i] <= '0;
            end
        end else begin
            wr_stb <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else if (start_det) begin
                state   <= DEV_ADR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                if (scl_rise && bit_cnt != 4'd8 &&
                    (state == DEV_ADR || state == REG_ADDR ||
                     state == WR_DATA)) begin
                    shreg   <= {shreg[6:0], sda_f};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    DEV_ADR: begin
                        if (scl_fall && bit_cnt == 4'd8) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                                state  <= DEV_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shreg   <= regbank[ptr];
                                sda_oe  <= ~regbank[ptr][7];
                                bit_cnt <= 4'd1;
                                state   <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= REG_ADDR;
                            end
                        end
                    end
                    REG_ADDR: begin
                        if (scl_fall && bit_cnt == 4'd8) begin
                            if (reg_ok) begin
                                sda_oe <= 1'b1;
                                ptr    <= shreg[AW-1:0];
                                state  <= REG_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    REG_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe       <= 1'b1;
                            regbank[ptr] <= shreg;
                            wr_stb       <= 1'b1;
                            wr_addr      <= ptr;
                            wr_data      <= shreg;
                            ptr          <= ptr_inc;
                            state        <= WR_ACK;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe  <= ~shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        // pointer moves past every byte sent, ACKed or not
                        if (scl_rise) begin
                            ptr <= ptr_inc;
                            if (sda_f) begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall) begin
                            shreg   <= regbank[ptr];
                            sda_oe  <= ~regbank[ptr][7];
                            bit_cnt <= 4'd1;
                            state   <= RD_DATA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Directed bench for i2c_target_regbank: bit-banged I2C master,
// write-strobe scoreboard queue and read-data expectation queue.
module tb_i2c_target_regbank;

    localparam int Q = 20;

    logic       clk_12M = 1'b0;
    logic       rstn;
    logic       i2c_sclk;
    logic       m_sda;
    wire        sda;
    logic       busy;
    logic       wr_stb;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] host_rd_addr;
    logic [7:0] host_rd_data;

    int         checks = 0;
    int         errors = 0;
    logic [13:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic        drv_seen;
    logic        a;
    logic [7:0]  d;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #42 clk_12M = ~clk_12M;

    i2c_target_regbank dut (
        .clk_12M      (clk_12M),
        .rstn         (rstn),
        .i2c_sclk     (i2c_sclk),
        .i2c_sdat     (sda),
        .busy         (busy),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_12M);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        tick(Q);
        i2c_sclk = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        i2c_sclk = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        tick(Q);
        i2c_sclk = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            tick(Q);
            i2c_sclk = 1'b1;
            tick(2 * Q);
            i2c_sclk = 1'b0;
            tick(Q);
        end
        m_sda = 1'b1;
        tick(Q);
        i2c_sclk = 1'b1;
        tick(Q);
        ack = sda;
        tick(Q);
        i2c_sclk = 1'b0;
        tick(Q);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] v);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            i2c_sclk = 1'b1;
            tick(Q);
            v[i] = sda;
            tick(Q);
            i2c_sclk = 1'b0;
            tick(Q);
        end
        m_sda = nack;
        tick(Q);
        i2c_sclk = 1'b1;
        tick(2 * Q);
        i2c_sclk = 1'b0;
        tick(Q);
        m_sda = 1'b1;
    endtask

    task automatic host_chk(input string tag, input logic [5:0] ad,
                            input logic [7:0] exp);
        host_rd_addr = ad;
        #1;
        chk(tag, {8'd0, host_rd_data}, {8'd0, exp});
    endtask

    initial begin
        rstn         = 1'b0;
        i2c_sclk     = 1'b1;
        m_sda        = 1'b1;
        host_rd_addr = '0;
        drv_seen     = 1'b0;

        fork
            forever begin
                @(negedge clk_12M);
                if (m_sda && !sda) drv_seen = 1'b1;
                if (rstn && wr_stb) begin
                    checks++;
                    assert (exp_wr.size() > 0) else begin
                        errors++;
                        $error("FAIL wr_unexpected observed %0h:%0h expected none",
                               wr_addr, wr_data);
                    end
                    if (exp_wr.size() > 0)
                        chk("wr_stb", {2'b0, wr_addr, wr_data},
                            {2'b0, exp_wr.pop_front()});
                end
            end
        join_none

        tick(5);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_wr_stb", 16'(wr_stb), 16'h0);
        chk("rst_wr_addr", 16'(wr_addr), 16'h0);
        chk("rst_wr_data", 16'(wr_data), 16'h0);
        chk("rst_sda", 16'(sda), 16'h1);
        host_chk("rst_reg0", 6'd0, 8'h00);
        rstn = 1'b1;
        tick(10);

        // 1: single write
        bus_start();
        wr_byte(8'h20, a); chk("t1_ack_dev", 16'(a), 16'h0);
        chk("t1_busy", 16'(busy), 16'h1);
        wr_byte(8'h05, a); chk("t1_ack_reg", 16'(a), 16'h0);
        exp_wr.push_back({6'h05, 8'hA5});
        wr_byte(8'hA5, a); chk("t1_ack_dat", 16'(a), 16'h0);
        bus_stop();
        chk("t1_busy_end", 16'(busy), 16'h0);
        host_chk("t1_reg5", 6'd5, 8'hA5);

        // 2: burst wrapping past the top register
        bus_start();
        wr_byte(8'h20, a); chk("t2_ack_dev", 16'(a), 16'h0);
        wr_byte(8'h3F, a); chk("t2_ack_reg", 16'(a), 16'h0);
        exp_wr.push_back({6'h3F, 8'h11});
        wr_byte(8'h11, a); chk("t2_ack_d0", 16'(a), 16'h0);
        exp_wr.push_back({6'h00, 8'h22});
        wr_byte(8'h22, a); chk("t2_ack_d1", 16'(a), 16'h0);
        exp_wr.push_back({6'h01, 8'h33});
        wr_byte(8'h33, a); chk("t2_ack_d2", 16'(a), 16'h0);
        bus_stop();
        host_chk("t2_reg3f", 6'h3F, 8'h11);
        host_chk("t2_reg0", 6'h00, 8'h22);

        // 3: foreign device address
        drv_seen = 1'b0;
        bus_start();
        wr_byte(8'h22, a); chk("t3_nack_dev", 16'(a), 16'h1);
        chk("t3_busy", 16'(busy), 16'h0);
        wr_byte(8'h05, a); chk("t3_nack_b1", 16'(a), 16'h1);
        wr_byte(8'hEE, a); chk("t3_nack_b2", 16'(a), 16'h1);
        bus_stop();
        chk("t3_no_drive", 16'(drv_seen), 16'h0);
        host_chk("t3_reg5", 6'd5, 8'hA5);

        // setup for reads: regs 6,7
        bus_start();
        wr_byte(8'h20, a); chk("s_ack_dev", 16'(a), 16'h0);
        wr_byte(8'h06, a); chk("s_ack_reg", 16'(a), 16'h0);
        exp_wr.push_back({6'h06, 8'h66});
        wr_byte(8'h66, a);
        exp_wr.push_back({6'h07, 8'h77});
        wr_byte(8'h77, a);
        bus_stop();

        // 4: pointer set, repeated start, 2-byte read
        bus_start();
        wr_byte(8'h20, a); chk("t4_ack_dev", 16'(a), 16'h0);
        wr_byte(8'h05, a); chk("t4_ack_reg", 16'(a), 16'h0);
        bus_start();
        wr_byte(8'h21, a); chk("t4_ack_rd", 16'(a), 16'h0);
        exp_rd.push_back(8'hA5);
        exp_rd.push_back(8'h66);
        rd_byte(1'b0, d); chk("t4_rd0", 16'(d), 16'(exp_rd.pop_front()));
        rd_byte(1'b1, d); chk("t4_rd1", 16'(d), 16'(exp_rd.pop_front()));
        bus_stop();
        bus_start();
        wr_byte(8'h21, a); chk("t4_ack_rd2", 16'(a), 16'h0);
        exp_rd.push_back(8'h77);
        rd_byte(1'b1, d); chk("t4_ptr7", 16'(d), 16'(exp_rd.pop_front()));
        bus_stop();

        // 5: register pointer out of range
        bus_start();
        wr_byte(8'h20, a); chk("t5_ack_dev", 16'(a), 16'h0);
        wr_byte(8'h40, a); chk("t5_nack_reg", 16'(a), 16'h1);
        wr_byte(8'h99, a); chk("t5_nack_dat", 16'(a), 16'h1);
        chk("t5_busy", 16'(busy), 16'h0);
        bus_stop();

        // 6: reset in the middle of a read byte
        bus_start();
        wr_byte(8'h20, a); chk("t6_ack_dev", 16'(a), 16'h0);
        wr_byte(8'h07, a); chk("t6_ack_reg", 16'(a), 16'h0);
        bus_start();
        wr_byte(8'h21, a); chk("t6_ack_rd", 16'(a), 16'h0);
        chk("t6_bit7_drv", 16'(sda), 16'h0);
        i2c_sclk = 1'b1;
        tick(Q);
        @(negedge clk_12M);
        rstn = 1'b0;
        @(posedge clk_12M);
        #1;
        chk("t6_rst_release", 16'(sda), 16'h1);
        chk("t6_rst_busy", 16'(busy), 16'h0);
        host_chk("t6_rst_reg5", 6'd5, 8'h00);
        host_chk("t6_rst_reg7", 6'd7, 8'h00);
        tick(3);
        rstn = 1'b1;
        i2c_sclk = 1'b0;
        tick(Q);
        bus_start();
        wr_byte(8'h20, a); chk("t6_ack_dev2", 16'(a), 16'h0);
        wr_byte(8'h02, a); chk("t6_ack_reg2", 16'(a), 16'h0);
        exp_wr.push_back({6'h02, 8'h3C});
        wr_byte(8'h3C, a); chk("t6_ack_dat2", 16'(a), 16'h0);
        bus_stop();
        host_chk("t6_reg2", 6'd2, 8'h3C);

        tick(10);
        chk("wr_queue_empty", 16'(exp_wr.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
